// File: rtl/tinychip_pkg.sv
// Shared types for the TinyChip host-side supervisor and controller.
// Holds the supervisor state encoding and the instruction word width.
package tinychip_pkg;

  localparam int INSTR_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE,
    TIMEOUT
  } sup_state_t;

endpackage

// File: rtl/run_supervisor.sv
// Loads a program into instruction memory, holds then releases the controller, and times the run.
// Memory writes land one cycle after each handshake; load_ready is asserted only in LOAD.
module run_supervisor
  import tinychip_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = tinychip_pkg::INSTR_W,
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    prog_len,
  input  logic [CNT_W-1:0]   timeout_limit,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               core_reset,
  input  logic               core_done,
  output logic               busy,
  output logic               finished,
  output logic               timed_out,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [ADDR_W:0]  DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam int               HOLD_W    = $clog2(RST_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  sup_state_t         state_q, state_d;
  logic [ADDR_W:0]    word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               finished_q, finished_d;
  logic               timed_out_q, timed_out_d;
  logic               im_we_q, im_we_d;
  logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
  logic [INSTR_W-1:0] im_wdata_q, im_wdata_d;
  logic [ADDR_W:0]    word_nxt;
  logic [CNT_W-1:0]   cyc_inc;

  assign word_nxt = word_cnt_q + 1'b1;
  assign cyc_inc  = (cycle_count_q == CNT_MAX) ? cycle_count_q : cycle_count_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    len_d         = len_q;
    limit_d       = limit_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    finished_d    = finished_q;
    timed_out_d   = timed_out_q;
    im_we_d       = 1'b0;
    im_addr_d     = im_addr_q;
    im_wdata_d    = im_wdata_q;

    case (state_q)
      IDLE, DONE, TIMEOUT: begin
        if (start) begin
          finished_d    = 1'b0;
          timed_out_d   = 1'b0;
          cycle_count_d = '0;
          word_cnt_d    = '0;
          hold_cnt_d    = '0;
          limit_d       = timeout_limit;
          len_d         = (prog_len > DEPTH) ? DEPTH : prog_len;
          state_d       = (prog_len == '0) ? HOLD : LOAD;
        end
      end
      LOAD: begin
        if (load_valid) begin
          im_we_d    = 1'b1;
          im_addr_d  = word_cnt_q[ADDR_W-1:0];
          im_wdata_d = load_data;
          word_cnt_d = word_nxt;
          if (word_nxt == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = RUN;
        else hold_cnt_d = hold_cnt_q + 1'b1;
      end
      RUN: begin
        cycle_count_d = cyc_inc;
        // A done seen in the same cycle the limit is reached counts as a finish.
        if (core_done) begin
          finished_d = 1'b1;
          state_d    = DONE;
        end else if ((limit_q != '0) && (cyc_inc == limit_q)) begin
          timed_out_d = 1'b1;
          state_d     = TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      len_q         <= '0;
      limit_q       <= '0;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      finished_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      im_we_q       <= 1'b0;
      im_addr_q     <= '0;
      im_wdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      len_q         <= len_d;
      limit_q       <= limit_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      finished_q    <= finished_d;
      timed_out_q   <= timed_out_d;
      im_we_q       <= im_we_d;
      im_addr_q     <= im_addr_d;
      im_wdata_q    <= im_wdata_d;
    end
  end

  assign load_ready  = (state_q == LOAD);
  assign core_reset  = (state_q != RUN);
  assign busy        = (state_q == LOAD) || (state_q == HOLD) || (state_q == RUN);
  assign finished    = finished_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;
  assign im_we       = im_we_q;
  assign im_addr     = im_addr_q;
  assign im_wdata    = im_wdata_q;

endmodule

// File: tb/tb_run_supervisor.sv
// Directed bench for run_supervisor: load handshakes, hold/run timing, done vs timeout, async reset.
module tb_run_supervisor;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  logic               clk;
  logic               reset;
  logic               start;
  logic [ADDR_W:0]    prog_len;
  logic [CNT_W-1:0]   timeout_limit;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;
  logic               core_reset;
  logic               core_done;
  logic               busy;
  logic               finished;
  logic               timed_out;
  logic [CNT_W-1:0]   cycle_count;

  int total;
  int bad;
  int lowcnt;

  run_supervisor #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .CNT_W  (CNT_W),
    .RST_CYC(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prog_len     (prog_len),
    .timeout_limit(timeout_limit),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_reset   (core_reset),
    .core_done    (core_done),
    .busy         (busy),
    .finished     (finished),
    .timed_out    (timed_out),
    .cycle_count  (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes n cycles, counting those with core_reset low; drives core_done on step done_at.
  task automatic run_obs(input int n, input int done_at, output int low);
    low = 0;
    for (int i = 0; i < n; i++) begin
      if (core_reset === 1'b0) low++;
      core_done = (i == done_at);
      tick();
    end
    core_done = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    start = 1'b0;
    prog_len = '0;
    timeout_limit = '0;
    load_valid = 1'b0;
    load_data = '0;
    core_done = 1'b0;

    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_finished", finished, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_cycle_count", cycle_count, 0);
    #11;
    reset = 1'b1;
    tick();

    // Load three words with gaps, then a fourth that must be refused.
    start = 1'b1;
    prog_len = 9'd3;
    timeout_limit = '0;
    tick();
    start = 1'b0;
    chk("load_ready_in_load", load_ready, 1);
    chk("busy_in_load", busy, 1);
    chk("no_write_before_hs", im_we, 0);
    load_valid = 1'b1;
    load_data = 9'h101;
    tick();
    chk("w0_we", im_we, 1);
    chk("w0_addr", im_addr, 0);
    chk("w0_data", im_wdata, 9'h101);
    load_valid = 1'b0;
    tick();
    chk("gap1_we", im_we, 0);
    load_valid = 1'b1;
    load_data = 9'h0A2;
    tick();
    chk("w1_we", im_we, 1);
    chk("w1_addr", im_addr, 1);
    chk("w1_data", im_wdata, 9'h0A2);
    load_valid = 1'b0;
    tick();
    tick();
    chk("gap2_we", im_we, 0);
    load_valid = 1'b1;
    load_data = 9'h1FF;
    tick();
    chk("w2_we", im_we, 1);
    chk("w2_addr", im_addr, 2);
    chk("w2_data", im_wdata, 9'h1FF);
    chk("ready_drops_after_last", load_ready, 0);
    load_data = 9'h0AA;
    tick();
    chk("w3_refused", im_we, 0);
    chk("hold_core_reset", core_reset, 1);
    load_valid = 1'b0;
    tick();
    chk("run_core_reset", core_reset, 0);
    chk("run_start_count", cycle_count, 0);

    // start during RUN is ignored.
    start = 1'b1;
    prog_len = 9'd0;
    tick();
    start = 1'b0;
    chk("ign_start_core_reset", core_reset, 0);
    chk("ign_start_busy", busy, 1);
    chk("ign_start_count", cycle_count, 1);
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("r1_finished", finished, 1);
    chk("r1_count", cycle_count, 3);
    chk("r1_core_reset", core_reset, 1);
    chk("r1_busy", busy, 0);

    // Zero-length program, no limit, done in the 10th RUN cycle.
    start = 1'b1;
    prog_len = 9'd0;
    timeout_limit = 16'd0;
    tick();
    start = 1'b0;
    chk("restart_clears_finished", finished, 0);
    chk("restart_clears_count", cycle_count, 0);
    chk("len0_goes_hold", load_ready, 0);
    run_obs(16, 11, lowcnt);
    chk("t3_low_cycles", lowcnt, 10);
    chk("t3_finished", finished, 1);
    chk("t3_timed_out", timed_out, 0);
    chk("t3_count", cycle_count, 10);
    chk("t3_core_reset", core_reset, 1);

    // One-word reload, limit 5, no done: timeout.
    start = 1'b1;
    prog_len = 9'd1;
    timeout_limit = 16'd5;
    tick();
    start = 1'b0;
    load_valid = 1'b1;
    load_data = 9'h055;
    tick();
    load_valid = 1'b0;
    chk("reload_we", im_we, 1);
    chk("reload_addr", im_addr, 0);
    chk("reload_data", im_wdata, 9'h055);
    run_obs(12, -1, lowcnt);
    chk("t4_low_cycles", lowcnt, 5);
    chk("t4_timed_out", timed_out, 1);
    chk("t4_finished", finished, 0);
    chk("t4_count", cycle_count, 5);

    // Limit 5 with done on the 5th RUN cycle: done wins.
    start = 1'b1;
    prog_len = 9'd0;
    timeout_limit = 16'd5;
    tick();
    start = 1'b0;
    chk("t5_clears_timed_out", timed_out, 0);
    run_obs(12, 6, lowcnt);
    chk("t5_low_cycles", lowcnt, 5);
    chk("t5_finished", finished, 1);
    chk("t5_timed_out", timed_out, 0);
    chk("t5_count", cycle_count, 5);

    // Async reset in the middle of a run.
    start = 1'b1;
    prog_len = 9'd0;
    timeout_limit = 16'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("pre_rst_core_reset", core_reset, 0);
    chk("pre_rst_count", cycle_count, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_core_reset", core_reset, 1);
    chk("async_busy", busy, 0);
    chk("async_im_we", im_we, 0);
    chk("async_count", cycle_count, 0);
    chk("async_finished", finished, 0);
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
